// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// Optional same-edge forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: address mux, optional forwarding, zero override.
// Forwarding from the write port exists only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  localparam int NREG    = 2 ** ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [NREG-1:0][DATA_W-1:0] mem,
  input  logic [NREG-1:0]            pend,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic                       flush,
  output logic [DATA_W-1:0]          data,
  output logic                       ready
);

  logic [DATA_W-1:0] sel_data;
  logic              sel_ready;
  logic              hit_zero;

  assign hit_zero = (ZERO_REG != 0) && (addr == '0);

`ifdef REGFILE_BYPASS_EN
  logic fwd_hit;
  logic rsv_hit;

  assign fwd_hit = wr_en && (wr_addr == addr);
  // A same-edge reserve re-arms the hazard unless flush cancels it.
  assign rsv_hit = rsv_en && (rsv_addr == addr) && !flush;
`else
  logic unused_byp;

  assign unused_byp = ^{wr_en, wr_addr, wr_data,
                        rsv_en, rsv_addr, flush};
`endif

  always_comb begin
    sel_data  = mem[addr];
    sel_ready = !pend[addr];
`ifdef REGFILE_BYPASS_EN
    if (fwd_hit) begin
      sel_data  = wr_data;
      sel_ready = !rsv_hit;
    end
`endif
    if (hit_zero) begin
      sel_data  = '0;
      sel_ready = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      ready <= 1'b1;
    end else if (rd_en) begin
      data  <= sel_data;
      ready <= sel_ready;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two registered read ports and a pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-edge writes to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  localparam int NREG    = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              a_ready,
  output logic              b_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic [NREG-1:0]   pend,
  output logic [ADDR_W:0]   pend_cnt
);

  logic [NREG-1:0][DATA_W-1:0] mem;
  logic [NREG-1:0]             pend_nxt;
  logic [ADDR_W:0]             cnt_nxt;
  logic                        wr_ok;
  logic                        rsv_ok;

  assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Order matters: reserve beats write, flush beats everything.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok) begin
      pend_nxt[wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      pend_nxt[rsv_addr] = 1'b1;
    end
    if (flush) begin
      pend_nxt = '0;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .addr     (rs_addr),
    .mem      (mem),
    .pend     (pend),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .data     (a),
    .ready    (a_ready)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .addr     (rt_addr),
    .mem      (mem),
    .pend     (pend),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .data     (b),
    .ready    (b_ready)
  );

endmodule
